// File: rtl/ahb_rom_arb_pkg.sv
// Shared definitions for the dual-port AHB-to-ROM arbiter: HTRANS codes,
// port FSM states and the default ROM base offset.
package ahb_rom_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int unsigned ROM_BASE_DEFAULT = 'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_GNT,
    ST_WAIT_DATA,
    ST_ERR1,
    ST_ERR2
  } port_state_e;

  function automatic logic [15:0] rom_offset(input logic [15:0] addr,
                                             input logic [15:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/ahb_rom_arb_port.sv
// One AHB slave port of the ROM arbiter: transfer capture, per-port FSM and
// response generation. Write error response enabled by AHB_ROM_ARB_ERR_EN.
module ahb_rom_arb_port
  import ahb_rom_arb_pkg::*;
#(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter int unsigned ROM_BASE       = ROM_BASE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      hsel_i,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
  input  logic                      hwrite_i,
  input  logic [1:0]                htrans_i,
  input  logic                      hready_i,
  output logic [AHB_DATA_WIDTH-1:0] hrdata_o,
  output logic                      hreadyout_o,
  output logic                      hresp_o,
  output logic                      req_o,
  output logic [15:0]               addr_o,
  input  logic                      gnt_i,
  input  logic [AHB_DATA_WIDTH-1:0] rom_rdata_i
);

  localparam logic [15:0] BASE16 = ROM_BASE[15:0];

  port_state_e state_q, state_n;
  logic [15:0] addr_q;
  logic        accept;
  logic        capture;
  logic        unused_haddr_hi;

  assign unused_haddr_hi = ^haddr_i[AHB_ADDR_WIDTH-1:16];

  assign accept = hsel_i & hready_i & htrans_i[1];
  // Only the idle state and the data-completion cycle can open a new transfer.
  assign capture = accept & ~hwrite_i &
                   ((state_q == ST_IDLE) || (state_q == ST_WAIT_DATA));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_n;
      if (capture) addr_q <= haddr_i[15:0];
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE, ST_WAIT_DATA: begin
        state_n = ST_IDLE;
        if (accept) begin
          if (!hwrite_i) begin
            state_n = ST_WAIT_GNT;
          end else begin
`ifdef AHB_ROM_ARB_ERR_EN
            state_n = ST_ERR1;
`else
            state_n = ST_IDLE;
`endif
          end
        end
      end
      ST_WAIT_GNT: if (gnt_i) state_n = ST_WAIT_DATA;
      ST_ERR1:     state_n = ST_ERR2;
      ST_ERR2:     state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = 1'b0;
    hrdata_o    = '0;
    req_o       = 1'b0;
    case (state_q)
      ST_WAIT_GNT: begin
        hreadyout_o = 1'b0;
        req_o       = 1'b1;
      end
      ST_WAIT_DATA: hrdata_o = rom_rdata_i;
      ST_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = 1'b1;
      end
      ST_ERR2: hresp_o = 1'b1;
      default: ;
    endcase
  end

  assign addr_o = rom_offset(addr_q, BASE16);

endmodule

// File: rtl/ahb_rom_arbiter.sv
// Two AHB slave ports sharing one ROM read port through a round-robin grant.
// Optional write error response: define AHB_ROM_ARB_ERR_EN.
module ahb_rom_arbiter
  import ahb_rom_arb_pkg::*;
#(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter int unsigned ROM_BASE       = ROM_BASE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      p0_hsel_i,
  input  logic [AHB_ADDR_WIDTH-1:0] p0_haddr_i,
  input  logic                      p0_hwrite_i,
  input  logic [1:0]                p0_htrans_i,
  input  logic                      p0_hready_i,
  output logic [AHB_DATA_WIDTH-1:0] p0_hrdata_o,
  output logic                      p0_hreadyout_o,
  output logic                      p0_hresp_o,
  input  logic                      p1_hsel_i,
  input  logic [AHB_ADDR_WIDTH-1:0] p1_haddr_i,
  input  logic                      p1_hwrite_i,
  input  logic [1:0]                p1_htrans_i,
  input  logic                      p1_hready_i,
  output logic [AHB_DATA_WIDTH-1:0] p1_hrdata_o,
  output logic                      p1_hreadyout_o,
  output logic                      p1_hresp_o,
  output logic                      rom_req_o,
  output logic [15:0]               rom_addr_o,
  input  logic [AHB_DATA_WIDTH-1:0] rom_rdata_i
);

  logic        req0, req1;
  logic        gnt0, gnt1;
  logic [15:0] addr0, addr1;
  logic        last_gnt1_q;

  ahb_rom_arb_port #(
    .AHB_ADDR_WIDTH(AHB_ADDR_WIDTH),
    .AHB_DATA_WIDTH(AHB_DATA_WIDTH),
    .ROM_BASE      (ROM_BASE)
  ) u_port0 (
    .clk        (clk),
    .rstn       (rstn),
    .hsel_i     (p0_hsel_i),
    .haddr_i    (p0_haddr_i),
    .hwrite_i   (p0_hwrite_i),
    .htrans_i   (p0_htrans_i),
    .hready_i   (p0_hready_i),
    .hrdata_o   (p0_hrdata_o),
    .hreadyout_o(p0_hreadyout_o),
    .hresp_o    (p0_hresp_o),
    .req_o      (req0),
    .addr_o     (addr0),
    .gnt_i      (gnt0),
    .rom_rdata_i(rom_rdata_i)
  );

  ahb_rom_arb_port #(
    .AHB_ADDR_WIDTH(AHB_ADDR_WIDTH),
    .AHB_DATA_WIDTH(AHB_DATA_WIDTH),
    .ROM_BASE      (ROM_BASE)
  ) u_port1 (
    .clk        (clk),
    .rstn       (rstn),
    .hsel_i     (p1_hsel_i),
    .haddr_i    (p1_haddr_i),
    .hwrite_i   (p1_hwrite_i),
    .htrans_i   (p1_htrans_i),
    .hready_i   (p1_hready_i),
    .hrdata_o   (p1_hrdata_o),
    .hreadyout_o(p1_hreadyout_o),
    .hresp_o    (p1_hresp_o),
    .req_o      (req1),
    .addr_o     (addr1),
    .gnt_i      (gnt1),
    .rom_rdata_i(rom_rdata_i)
  );

  // On contention the port that was not granted most recently wins.
  assign gnt0 = req0 & (~req1 | last_gnt1_q);
  assign gnt1 = req1 & (~req0 | ~last_gnt1_q);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_gnt1_q <= 1'b1;
    end else if (gnt0 | gnt1) begin
      last_gnt1_q <= gnt1;
    end
  end

  always_comb begin
    rom_req_o  = gnt0 | gnt1;
    rom_addr_o = '0;
    if (gnt0)      rom_addr_o = addr0;
    else if (gnt1) rom_addr_o = addr1;
  end

endmodule

// File: tb/tb_ahb_rom_arbiter.sv
// Randomized and directed bench for ahb_rom_arbiter against a
// transaction-level reference model of the two ports and the shared ROM.
module tb_ahb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hsel[2];
  logic [31:0] haddr[2];
  logic        hwrite[2];
  logic [1:0]  htrans[2];
  logic        hready[2];
  logic [31:0] hrdata[2];
  logic        hreadyout[2];
  logic        hresp[2];
  logic        rom_req;
  logic [15:0] rom_addr;
  logic [31:0] rom_rdata;

  int unsigned tests_run = 0;
  int unsigned errors    = 0;

  // Reference model: outstanding ROM request, data due this cycle, error phases
  logic        m_pend[2];
  logic [15:0] m_addr[2];
  logic        m_due[2];
  logic        m_e1[2];
  logic        m_e2[2];
  int          m_last;

  always #5 clk = ~clk;

  ahb_rom_arbiter dut (
    .clk           (clk),
    .rstn          (rstn),
    .p0_hsel_i     (hsel[0]),
    .p0_haddr_i    (haddr[0]),
    .p0_hwrite_i   (hwrite[0]),
    .p0_htrans_i   (htrans[0]),
    .p0_hready_i   (hready[0]),
    .p0_hrdata_o   (hrdata[0]),
    .p0_hreadyout_o(hreadyout[0]),
    .p0_hresp_o    (hresp[0]),
    .p1_hsel_i     (hsel[1]),
    .p1_haddr_i    (haddr[1]),
    .p1_hwrite_i   (hwrite[1]),
    .p1_htrans_i   (htrans[1]),
    .p1_hready_i   (hready[1]),
    .p1_hrdata_o   (hrdata[1]),
    .p1_hreadyout_o(hreadyout[1]),
    .p1_hresp_o    (hresp[1]),
    .rom_req_o     (rom_req),
    .rom_addr_o    (rom_addr),
    .rom_rdata_i   (rom_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_winner();
    if (m_pend[0] && m_pend[1]) return (m_last == 0) ? 1 : 0;
    if (m_pend[0]) return 0;
    if (m_pend[1]) return 1;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int n = 0; n < 2; n++) begin
      m_pend[n] = 1'b0;
      m_addr[n] = '0;
      m_due[n]  = 1'b0;
      m_e1[n]   = 1'b0;
      m_e2[n]   = 1'b0;
    end
    m_last = 1;
  endfunction

  task automatic step_chk();
    int g;
    #1;
    g = model_winner();
    check("rom_req", {31'd0, rom_req}, {31'd0, g >= 0});
    check("rom_addr", {16'd0, rom_addr}, (g >= 0) ? {16'd0, m_addr[g] - 16'h0080} : 32'd0);
    for (int n = 0; n < 2; n++) begin
      check($sformatf("p%0d_hreadyout", n), {31'd0, hreadyout[n]}, {31'd0, !m_pend[n] && !m_e1[n]});
      check($sformatf("p%0d_hresp", n), {31'd0, hresp[n]}, {31'd0, m_e1[n] || m_e2[n]});
      check($sformatf("p%0d_hrdata", n), hrdata[n], m_due[n] ? rom_rdata : 32'd0);
    end
  endtask

  task automatic step_adv();
    int   g;
    logic acc;
    if (!rstn) begin
      model_reset();
    end else begin
      g = model_winner();
      for (int n = 0; n < 2; n++) begin
        acc = hsel[n] && hready[n] && htrans[n][1] && !m_pend[n] && !m_e1[n] && !m_e2[n];
        m_due[n]  = (g == n);
        m_pend[n] = m_pend[n] && (g != n);
        m_e2[n]   = m_e1[n];
        m_e1[n]   = 1'b0;
        if (acc) begin
          if (!hwrite[n]) begin
            m_pend[n] = 1'b1;
            m_addr[n] = haddr[n][15:0];
          end else begin
`ifdef AHB_ROM_ARB_ERR_EN
            m_e1[n] = 1'b1;
`endif
          end
        end
      end
      if (g >= 0) m_last = g;
    end
    @(negedge clk);
  endtask

  task automatic tick();
    step_chk();
    step_adv();
  endtask

  task automatic drive(input int n, input logic [1:0] tr, input logic [31:0] a, input logic wr);
    hsel[n]   = (tr != 2'b00);
    htrans[n] = tr;
    haddr[n]  = a;
    hwrite[n] = wr;
    hready[n] = 1'b1;
  endtask

  task automatic idle_all();
    drive(0, 2'b00, 32'd0, 1'b0);
    drive(1, 2'b00, 32'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] r;
    rstn = 1'b0;
    rom_rdata = 32'hDEAD_BEEF;
    idle_all();
    @(negedge clk);
    @(negedge clk);
    model_reset();
    step_chk();
    step_adv();
    rstn = 1'b1;

    // Reset state
    step_chk();
    check("rst_p0_ready", {31'd0, hreadyout[0]}, 32'd1);
    check("rst_p1_ready", {31'd0, hreadyout[1]}, 32'd1);
    check("rst_rom_req", {31'd0, rom_req}, 32'd0);
    check("rst_p0_hrdata", hrdata[0], 32'd0);
    step_adv();

    // Single read from p0 at 0x84
    drive(0, 2'b10, 32'h0000_0084, 1'b0);
    tick();
    idle_all();
    step_chk();
    check("single_req", {31'd0, rom_req}, 32'd1);
    check("single_addr", {16'd0, rom_addr}, 32'h0004);
    check("single_wait", {31'd0, hreadyout[0]}, 32'd0);
    step_adv();
    rom_rdata = 32'h1234_5678;
    step_chk();
    check("single_data", hrdata[0], 32'h1234_5678);
    check("single_done", {31'd0, hreadyout[0]}, 32'd1);
    step_adv();

    // Simultaneous reads: pointer favours p0 after the previous p0 grant? no -
    // p0 was granted last, so set up contention after a p1 solo grant first.
    drive(1, 2'b10, 32'h0000_0090, 1'b0);
    tick();
    idle_all();
    tick();
    tick();
    drive(0, 2'b10, 32'h0000_00A0, 1'b0);
    drive(1, 2'b10, 32'h0000_00B0, 1'b0);
    tick();
    idle_all();
    step_chk();
    check("rr1_first", {16'd0, rom_addr}, 32'h0020);
    check("rr1_p1_wait", {31'd0, hreadyout[1]}, 32'd0);
    step_adv();
    step_chk();
    check("rr1_second", {16'd0, rom_addr}, 32'h0030);
    check("rr1_p0_done", {31'd0, hreadyout[0]}, 32'd1);
    check("rr1_p1_wait2", {31'd0, hreadyout[1]}, 32'd0);
    step_adv();
    tick();
    // Repeat after a p0 solo grant: p1 now wins the contention
    drive(0, 2'b10, 32'h0000_0100, 1'b0);
    tick();
    idle_all();
    tick();
    tick();
    drive(0, 2'b10, 32'h0000_00C0, 1'b0);
    drive(1, 2'b10, 32'h0000_00D0, 1'b0);
    tick();
    idle_all();
    step_chk();
    check("rr2_first_p1", {16'd0, rom_addr}, 32'h0050);
    step_adv();
    step_chk();
    check("rr2_second_p0", {16'd0, rom_addr}, 32'h0040);
    step_adv();
    tick();

    // Four-beat SEQ burst on p0 from 0x80
    drive(0, 2'b10, 32'h0000_0080, 1'b0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) drive(0, 2'b11, 32'h80 + 32'(4 * i), 1'b0);
      else       drive(0, 2'b00, 32'd0, 1'b0);
      step_chk();
      check($sformatf("burst_addr%0d", i - 1), {16'd0, rom_addr}, 32'(4 * (i - 1)));
      check($sformatf("burst_wait%0d", i - 1), {31'd0, hreadyout[0]}, 32'd0);
      step_adv();
      rom_rdata = $urandom;
      step_chk();
      check($sformatf("burst_done%0d", i - 1), {31'd0, hreadyout[0]}, 32'd1);
      step_adv();
    end

    // Address wrap below ROM_BASE
    drive(1, 2'b10, 32'h0000_0040, 1'b0);
    tick();
    idle_all();
    step_chk();
    check("wrap_addr", {16'd0, rom_addr}, 32'hFFC0);
    step_adv();
    tick();

    // Write on p1
    drive(1, 2'b10, 32'h0000_0088, 1'b1);
    step_chk();
    check("wr_addr_ready", {31'd0, hreadyout[1]}, 32'd1);
    step_adv();
    idle_all();
    step_chk();
    check("wr_no_req", {31'd0, rom_req}, 32'd0);
`ifdef AHB_ROM_ARB_ERR_EN
    check("wr_err1_resp", {31'd0, hresp[1]}, 32'd1);
    check("wr_err1_ready", {31'd0, hreadyout[1]}, 32'd0);
    step_adv();
    step_chk();
    check("wr_err2_resp", {31'd0, hresp[1]}, 32'd1);
    check("wr_err2_ready", {31'd0, hreadyout[1]}, 32'd1);
`else
    check("wr_okay_resp", {31'd0, hresp[1]}, 32'd0);
    check("wr_okay_ready", {31'd0, hreadyout[1]}, 32'd1);
`endif
    step_adv();
    tick();

    // Reset while p1 is in its data phase
    drive(1, 2'b10, 32'h0000_0200, 1'b0);
    tick();
    idle_all();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    rom_rdata = 32'hA5A5_5A5A;
    step_chk();
    check("mrst_p1_ready", {31'd0, hreadyout[1]}, 32'd1);
    check("mrst_p1_resp", {31'd0, hresp[1]}, 32'd0);
    check("mrst_req", {31'd0, rom_req}, 32'd0);
    check("mrst_p1_hrdata", hrdata[1], 32'd0);
    step_adv();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        hsel[n]   = ($urandom_range(0, 3) != 0);
        htrans[n] = 2'($urandom);
        hwrite[n] = ($urandom_range(0, 3) == 0);
        hready[n] = ($urandom_range(0, 9) != 0);
        r = $urandom;
        haddr[n]  = r;
      end
      rom_rdata = $urandom;
      rstn = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, errors);
    $finish;
  end

endmodule
